// File: rtl/lram_rec_pkg.sv
// Shared definitions for the LRAM pattern recorder.
//   rec_state_e : recorder FSM states (IDLE, REC, PLAY)
//   addr_w()    : RAM address width for a given depth
//   len_w()     : frame-count width for a given depth (one extra bit so DEPTH fits)
package lram_rec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } rec_state_e;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int len_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lram_sp.sv
// Inferred single-port RAM intended to map onto LIFCL large RAM (LRAM).
// Ports:
//   clk   : clock
//   we    : write enable, writes wdata to addr on the rising edge
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (read-before-write, one cycle latency)
// Contents are not reset.
module lram_sp #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  (* ram_style="huge" *) logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lram_pattern_recorder.sv
// Record/playback LED demo built around a single-port LRAM.
// A bouncing one-hot scanner advances once per tick (every 2^DIV_W clocks).
// In REC each scanner frame is stored to RAM; in PLAY the stored frames are
// replayed in a loop and drive the LEDs.
// Ports:
//   clk       : system clock
//   rst       : synchronous reset, active-high
//   rec_n     : record button, active-low
//   play_n    : play button, active-low
//   led       : LED drive, active-low (all ones = all off)
//   busy      : high while recording or playing
//   frame_len : number of frames in the latest recording
// Build option:
//   LRAM_REC_BTN_SYNC_EN : when defined, both buttons go through a 2-flop
//   synchroniser (reset to released) before the FSM samples them.
module lram_pattern_recorder
  import lram_rec_pkg::*;
#(
  parameter int LED_W  = 14,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int DIV_W  = 21
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rec_n,
  input  logic                       play_n,
  output logic [LED_W-1:0]           led,
  output logic                       busy,
  output logic [len_w(DEPTH)-1:0]    frame_len
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int LEN_W  = len_w(DEPTH);

  logic [DIV_W-1:0]  div;
  logic              tick;
  logic [LED_W-1:0]  shift, shift_d;
  logic              dir, dir_d;
  rec_state_e        state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [LEN_W-1:0]  flen_d;
  logic              ram_we;
  logic              rd_vld_p0, rd_vld_p1;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] disp;
  logic              rec_btn, play_btn;
  logic              unused_disp;

  assign tick        = &div;
  assign unused_disp = ^disp;

`ifdef LRAM_REC_BTN_SYNC_EN
  logic [1:0] rec_sync, play_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_sync  <= 2'b11;
      play_sync <= 2'b11;
    end else begin
      rec_sync  <= {rec_sync[0], rec_n};
      play_sync <= {play_sync[0], play_n};
    end
  end

  assign rec_btn  = rec_sync[1];
  assign play_btn = play_sync[1];
`else
  assign rec_btn  = rec_n;
  assign play_btn = play_n;
`endif

  // Scanner next value: the direction flips at either end, and the rotate
  // uses the freshly updated direction so the dot bounces without stalling.
  always_comb begin
    dir_d   = dir;
    shift_d = shift;
    if (shift == '0) begin
      shift_d = LED_W'(1);
    end else begin
      if (shift[LED_W-1]) begin
        dir_d = 1'b1;
      end else if (shift[0]) begin
        dir_d = 1'b0;
      end
      shift_d = dir_d ? {shift[0], shift[LED_W-1:1]}
                      : {shift[LED_W-2:0], shift[LED_W-1]};
    end
  end

  // Recorder FSM; every transition and RAM access happens on a tick.
  always_comb begin
    state_d   = state;
    addr_d    = addr;
    flen_d    = frame_len;
    ram_we    = 1'b0;
    rd_vld_p0 = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (!rec_btn) begin
            state_d = REC;
            addr_d  = '0;
          end else if (!play_btn && frame_len != '0) begin
            state_d = PLAY;
            addr_d  = '0;
          end
        end
        REC: begin
          if (rec_btn) begin
            flen_d  = LEN_W'(addr);
            state_d = IDLE;
          end else begin
            ram_we = 1'b1;
            if (addr == ADDR_W'(DEPTH - 1)) begin
              flen_d  = LEN_W'(DEPTH);
              state_d = IDLE;
            end else begin
              addr_d = addr + 1'b1;
            end
          end
        end
        PLAY: begin
          if (play_btn) begin
            state_d = IDLE;
          end else begin
            rd_vld_p0 = 1'b1;
            addr_d    = ({1'b0, addr} == frame_len - 1'b1) ? '0 : addr + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  lram_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr),
    .wdata (DATA_W'(shift)),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      shift     <= '0;
      dir       <= 1'b0;
      state     <= IDLE;
      addr      <= '0;
      frame_len <= '0;
      rd_vld_p1 <= 1'b0;
      disp      <= '0;
      led       <= '1;
      busy      <= 1'b0;
    end else begin
      div <= div + 1'b1;
      if (tick) begin
        shift <= shift_d;
        dir   <= dir_d;
      end
      state     <= state_d;
      addr      <= addr_d;
      frame_len <= flen_d;
      // p0 -> p1: RAM read issued on the tick, captured into disp next cycle
      rd_vld_p1 <= rd_vld_p0;
      if (rd_vld_p1) begin
        disp <= ram_rdata;
      end
      // p1 -> p2: output registers follow their sources by one cycle
      busy <= (state != IDLE);
      led  <= (state == PLAY) ? ~disp[LED_W-1:0] : ~shift;
    end
  end

endmodule

// File: tb/tb_lram_pattern_recorder.sv
module tb_lram_pattern_recorder;

  localparam int LED_W  = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int DIV_W  = 2;

  logic             clk;
  logic             rst;
  logic             rec_n;
  logic             play_n;
  logic [LED_W-1:0] led;
  logic             busy;
  logic [3:0]       frame_len;

  lram_pattern_recorder #(
    .LED_W  (LED_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DIV_W  (DIV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rec_n     (rec_n),
    .play_n    (play_n),
    .led       (led),
    .busy      (busy),
    .frame_len (frame_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         at;
    string      nm;
    logic [3:0] led;
    logic       busy;
    logic [3:0] flen;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   r0    = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc++;

  // Monitor: compares DUT outputs against queued expectations at their cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.at != cyc) begin
        bad++;
        $display("FAIL %s: sample cycle %0d missed (now %0d)", e.nm, e.at, cyc);
      end else if (led !== e.led || busy !== e.busy || frame_len !== e.flen) begin
        bad++;
        $display("FAIL %s: got led=%b busy=%b frame_len=%0d, want led=%b busy=%b frame_len=%0d",
                 e.nm, led, busy, frame_len, e.led, e.busy, e.flen);
      end
    end
  end

  task automatic expect_at(input int rel, input string nm, input logic [3:0] l,
                           input logic b, input logic [3:0] f);
    exp_t e;
    e.at   = r0 + rel;
    e.nm   = nm;
    e.led  = l;
    e.busy = b;
    e.flen = f;
    q.push_back(e);
  endtask

  task automatic go(input int rel);
    while (cyc < r0 + rel) @(negedge clk);
  endtask

  // One reset edge; r0 marks the reset edge so ticks land at r0+4k.
  task automatic do_reset();
    rst = 1'b1;
    r0  = cyc + 1;
    expect_at(0, "reset", 4'hF, 1'b0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    rec_n  = 1'b1;
    play_n = 1'b1;

    // Idle scanner after reset
    do_reset();
    expect_at(4,  "s1_pre_tick", 4'hF, 1'b0, 4'd0);
    expect_at(5,  "s1_shift1",   4'hE, 1'b0, 4'd0);
    expect_at(8,  "s1_hold1",    4'hE, 1'b0, 4'd0);
    expect_at(9,  "s1_shift2",   4'hD, 1'b0, 4'd0);
    expect_at(13, "s1_shift4",   4'hB, 1'b0, 4'd0);
    expect_at(17, "s1_shift8",   4'h7, 1'b0, 4'd0);
    expect_at(21, "s1_back4",    4'hB, 1'b0, 4'd0);
    expect_at(25, "s1_back2",    4'hD, 1'b0, 4'd0);
    expect_at(29, "s1_back1",    4'hE, 1'b0, 4'd0);
    expect_at(33, "s1_again2",   4'hD, 1'b0, 4'd0);
    go(40);

    do_reset();
    // Record three frames 1,2,4
    expect_at(4,   "s2_idle",      4'hF, 1'b0, 4'd0);
    expect_at(5,   "s2_rec_busy",  4'hE, 1'b1, 4'd0);
    expect_at(9,   "s2_rec_a",     4'hD, 1'b1, 4'd0);
    expect_at(13,  "s2_rec_b",     4'hB, 1'b1, 4'd0);
    expect_at(17,  "s2_rec_c",     4'h7, 1'b1, 4'd0);
    expect_at(20,  "s2_len3",      4'h7, 1'b1, 4'd3);
    expect_at(21,  "s2_idle_back", 4'hB, 1'b0, 4'd3);
    // Playback loops 1,2,4
    expect_at(25,  "s3_stale0",    4'hF, 1'b1, 4'd3);
    expect_at(29,  "s3_disp_lag",  4'hF, 1'b1, 4'd3);
    expect_at(30,  "s3_p1",        4'hE, 1'b1, 4'd3);
    expect_at(34,  "s3_p2",        4'hD, 1'b1, 4'd3);
    expect_at(38,  "s3_p4",        4'hB, 1'b1, 4'd3);
    expect_at(42,  "s3_wrap1",     4'hE, 1'b1, 4'd3);
    expect_at(46,  "s3_wrap2",     4'hD, 1'b1, 4'd3);
    expect_at(50,  "s3_wrap4",     4'hB, 1'b1, 4'd3);
    expect_at(54,  "s3_wrap1b",    4'hE, 1'b1, 4'd3);
    expect_at(56,  "s3_last_play", 4'hE, 1'b1, 4'd3);
    expect_at(57,  "s3_stop",      4'hD, 1'b0, 4'd3);
    // Full-depth record with auto-return and re-entry
    expect_at(61,  "s4_rec",       4'hB, 1'b1, 4'd3);
    expect_at(92,  "s4_full8",     4'h7, 1'b1, 4'd8);
    expect_at(93,  "s4_auto_idle", 4'hB, 1'b0, 4'd8);
    expect_at(96,  "s4_idle_held", 4'hB, 1'b0, 4'd8);
    expect_at(97,  "s4_reenter",   4'hD, 1'b1, 4'd8);
    expect_at(108, "s4_len2",      4'hD, 1'b1, 4'd2);
    expect_at(109, "s4_idle",      4'hB, 1'b0, 4'd2);
    // Simultaneous press, then play with nothing recorded
    expect_at(113, "s5_rec_wins",  4'h7, 1'b1, 4'd2);
    expect_at(116, "s5_len0",      4'h7, 1'b1, 4'd0);
    expect_at(117, "s5_idle",      4'hB, 1'b0, 4'd0);
    expect_at(121, "s5_play_empty",4'hD, 1'b0, 4'd0);
    expect_at(125, "s5_still_idle",4'hE, 1'b0, 4'd0);
    // Record 2,4 then play, reset in the middle
    expect_at(141, "s6_idle",      4'hB, 1'b0, 4'd2);
    expect_at(145, "s6_stale_disp",4'hE, 1'b1, 4'd2);
    expect_at(150, "s6_p2",        4'hD, 1'b1, 4'd2);
    expect_at(154, "s6_p4",        4'hB, 1'b1, 4'd2);
    expect_at(158, "s6_wrap2",     4'hD, 1'b1, 4'd2);

    rec_n = 1'b0;
    go(16);  rec_n = 1'b1;
    go(20);  play_n = 1'b0;
    go(52);  play_n = 1'b1;
    go(56);  rec_n = 1'b0;
    go(104); rec_n = 1'b1;
    go(108); rec_n = 1'b0; play_n = 1'b0;
    go(112); rec_n = 1'b1; play_n = 1'b1;
    go(116); play_n = 1'b0;
    go(124); play_n = 1'b1; rec_n = 1'b0;
    go(136); rec_n = 1'b1;
    go(140); play_n = 1'b0;
    go(158);

    // Reset during PLAY with play still held
    do_reset();
    expect_at(5,  "s6_post_idle1", 4'hE, 1'b0, 4'd0);
    expect_at(9,  "s6_post_idle2", 4'hD, 1'b0, 4'd0);
    expect_at(13, "s6_post_idle3", 4'hB, 1'b0, 4'd0);
    go(16);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
      total += q.size();
      bad   += q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish by time %0t, want finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lram_pattern_recorder.md
Name: lram_pattern_recorder

Overview:
Parametrised record/playback engine for the LIFCL LRAM, used as an LED demo on the LIFCL-40-EVN board.
- A bouncing one-hot LED scanner advances on a slow tick.
- While recording, each scanner frame is written to a large single-port RAM.
- While playing, the recorded frames are read back in order, loop continuously and drive the LEDs.

Parameters:
LED_W, 14, LED count / scanner width (≥2)
DATA_W, 16, RAM word width (≥ LED_W); upper bits zero-filled on write
DEPTH, 1024, RAM words; power of two, ≥2
DIV_W, 21, tick divider width; one tick every 2^DIV_W clocks

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous reset, active-high
rec_n  in  1  record button, active-low
play_n  in  1  play button, active-low
led  out  LED_W  LED drive, active-low
busy  out  1  high in REC or PLAY
frame_len  out  $clog2(DEPTH)+1  frames currently recorded

Behaviour:
- Tick: counter div[DIV_W-1:0] increments every clock. tick=1 for exactly one cycle when div is all-ones. After rst deassert, the first tick occurs at clock 2^DIV_W-1.
- Scanner (shift, LED_W bits), updated on tick in all states:
  - if shift==0: load 1
  - otherwise set dir: 1 if shift[LED_W-1], 0 if shift[0], else hold
  - then rotate right if dir=1, left if dir=0; dir uses the value updated this tick.
- FSM states IDLE, REC, PLAY. State changes only on tick:
  - IDLE: if rec_n=0, go to REC with addr=0. Else if play_n=0 and frame_len≠0, go to PLAY with addr=0. rec wins on a simultaneous press. play with frame_len=0 stays in IDLE.
  - REC, each tick:
    - if rec_n=1: frame_len=addr, go to IDLE, no write
    - else: write {zero, shift} to ram[addr]
      - if addr==DEPTH-1: frame_len=DEPTH, go to IDLE
      - else addr+1
  - PLAY, each tick:
    - if play_n=1: go to IDLE
    - else: read ram[addr]; addr = (addr==frame_len-1) ? 0 : addr+1
  - Buttons are sampled only on tick; a press shorter than one tick period may be missed.
- RAM:
  - Single port, one access per tick.
  - Write: data is in the RAM from the cycle after the tick.
  - Read: data is registered into disp at tick+1 (1-cycle latency), then held until the next read.
- led: ~shift in IDLE/REC; ~disp[LED_W-1:0] in PLAY. Registered; updates 1 cycle after the cycle its source changes.
- busy: registered from state.
- Reset values:
  - state=IDLE, div=0, shift=0, dir=0, addr=0, disp=0, frame_len=0
  - led = all ones (all LEDs off), busy=0
  - RAM contents are not reset.
- Reset mid-REC/PLAY: abort, frame_len returns to 0, and any recording in progress is discarded.
- Starting a new REC overwrites from address 0; frame_len reflects only the latest recording.

Optional Feature:
LRAM_REC_BTN_SYNC_EN.
- Defined: rec_n and play_n each pass through a 2-flop synchroniser (reset to 1) before the FSM samples them. This adds 2 clocks of input latency.
- Undefined: the FSM samples the raw inputs directly on tick.
- Tick-level behaviour is identical in both builds provided buttons are stable ≥3 clocks around the tick.

Decomposition:
- Package lram_rec_pkg:
  - state enum {IDLE, REC, PLAY}
  - ADDR_W/LEN_W helper functions derived from DEPTH
- Sub-module lram_sp:
  - Inferred single-port RAM with (* ram_style="huge" *).
  - Ports: clk, we, addr, wdata, rdata; registered read.
  - Parameters DATA_W, DEPTH.
- The top holds the divider, scanner, FSM and output registers.

Test Plan:
All scenarios use LED_W=4, DATA_W=8, DEPTH=8, DIV_W=2 (tick every 4 clocks).
1. Reset, buttons high, run 40 clocks:
   - led=4'b1111 until the first tick
   - then shift sequence 1,2,4,8,4,2,1,2 (led = complement)
   - busy=0
2. Hold rec_n=0 for 3 ticks, then release:
   - RAM[0..2]=0x01,0x02,0x04
   - frame_len=3 after the release tick
   - busy high only during REC
3. After scenario 2, hold play_n=0 for 7 ticks:
   - disp sequence 0x01,0x02,0x04,0x01,0x02,0x04,0x01
   - led=~disp[3:0], each 1 cycle after the corresponding disp update
4. Hold rec_n=0 for 12 ticks:
   - exactly 8 writes, then auto-return to IDLE with frame_len=8 while rec_n is still low
   - next tick re-enters REC, because the button is still held
5. Overlap and empty cases:
   - rec_n and play_n low on the same tick from IDLE → REC
   - play_n low with frame_len=0 → stays IDLE, busy=0
6. Assert rst during PLAY:
   - next clock: led=4'b1111, busy=0, frame_len=0
   - play_n held low after reset → remains IDLE
